// File: rtl/wb_spi_sram_pkg.sv
// Shared types and constants for the Wishbone-to-SPI-SRAM bridge.
// Frame layout is {cmd, 24-bit address, data byte}, shifted MSB first.
package wb_spi_sram_pkg;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam int         FRAME_BITS = 40;
    localparam int         DATA_BITS  = 8;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, GUARD} state_t;

    // Reads send a zero data byte; the SRAM drives MISO during that slot.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic we,
                                                          input logic [23:0] adr,
                                                          input logic [DATA_BITS-1:0] dat);
        return {(we ? CMD_WRITE : CMD_READ), adr, (we ? dat : 8'h00)};
    endfunction

endpackage

// File: rtl/wb_spi_sram_if.sv
// Single-beat Wishbone slave port bundle; the slave modport is the SRAM bridge side.
// Signal names keep the slave-relative _i/_o suffixes of the external port list.
interface wb_spi_sram_if import wb_spi_sram_pkg::*; #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = DATA_BITS,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8
) ();
    logic                  wb_cyc_i;
    logic                  wb_stb_i;
    logic [ADDR_WIDTH-1:0] wb_adr_i;
    logic                  wb_we_i;
    logic [SEL_WIDTH-1:0]  wb_sel_i;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic                  wb_ack_o;
    logic                  wb_err_o;
    logic                  wb_rty_o;
    logic [DATA_WIDTH-1:0] wb_dat_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_adr_i, wb_we_i, wb_sel_i, wb_dat_i,
        output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_adr_i, wb_we_i, wb_sel_i, wb_dat_i,
        input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
    );
endinterface

// File: rtl/wb_spi_sram_shift.sv
// Mode-0 SPI shifter for one 40-bit frame: 2*CLK_DIV clk cycles per bit, CS_N low for the whole frame.
// done is combinational on the final SCK fall; rx_byte then already includes the last MISO bit.
module spi_shift_engine import wb_spi_sram_pkg::*; #(
    parameter int CLK_DIV = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_BITS-1:0]  rx_byte,
    output logic                  sck,
    output logic                  cs_n,
    output logic                  mosi,
    input  logic                  miso
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0]         div_cnt;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] sh;
    logic [DATA_BITS-2:0]  rx;
    logic                  tick;

    assign tick    = busy && (div_cnt == DW'(CLK_DIV - 1));
    assign done    = tick && sck && (bit_cnt == 6'(FRAME_BITS - 1));
    assign rx_byte = {rx, miso};
    assign mosi    = sh[FRAME_BITS-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy    <= 1'b0;
            sck     <= 1'b0;
            cs_n    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            rx      <= '0;
        end else if (start && !busy) begin
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            sck     <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            sh      <= frame;
        end else if (busy) begin
            if (tick) begin
                div_cnt <= '0;
                sck     <= !sck;
                // Falling SCK: sample MISO at the end of the high phase, then advance MOSI.
                if (sck) begin
                    rx <= rx_byte[DATA_BITS-2:0];
                    if (done) begin
                        busy <= 1'b0;
                        cs_n <= 1'b1;
                        sh   <= '0;
                    end else begin
                        sh      <= {sh[FRAME_BITS-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/wb_spi_sram.sv
// Wishbone slave running one 23LC-style SPI READ/WRITE frame per access; ack 80*CLK_DIV+1 cycles after accept.
// One access outstanding; new requests wait in IDLE until CS_N has been high for CS_HIGH cycles.
module wb_spi_sram import wb_spi_sram_pkg::*; #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int CLK_DIV    = 1,
    parameter int CS_HIGH    = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    wb_spi_sram_if.slave  wb,
    output logic          spi_sck_o,
    output logic          spi_cs_n_o,
    output logic          spi_mosi_o,
    input  logic          spi_miso_i
);
    state_t                state_q, state_d;
    logic [7:0]            guard_q;
    logic                  we_q, abort_q, ack_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [ADDR_WIDTH-1:0] adr;
    logic [SEL_WIDTH-1:0]  sel;
    logic                  accept, null_wr, start, set_ack;
    logic                  eng_busy, eng_done;
    logic [DATA_BITS-1:0]  rx_byte;

    assign adr     = wb.wb_adr_i;
    assign sel     = wb.wb_sel_i;
    assign accept  = (state_q == IDLE) && wb.wb_cyc_i && wb.wb_stb_i && !ack_q;
    assign null_wr = accept && wb.wb_we_i && (sel == '0);

    spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   (start),
        .frame   (build_frame(wb.wb_we_i, 24'(adr), wb.wb_dat_i)),
        .busy    (eng_busy),
        .done    (eng_done),
        .rx_byte (rx_byte),
        .sck     (spi_sck_o),
        .cs_n    (spi_cs_n_o),
        .mosi    (spi_mosi_o),
        .miso    (spi_miso_i)
    );

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        set_ack = 1'b0;
        case (state_q)
            IDLE: begin
                if (null_wr) begin
                    set_ack = 1'b1;
                end else if (accept && !eng_busy) begin
                    start   = 1'b1;
                    state_d = SHIFT;
                end
            end
            // An abandoned cycle still finishes the frame but gets no ack.
            SHIFT: if (eng_done) begin
                state_d = DONE;
                set_ack = wb.wb_cyc_i && !abort_q;
            end
            DONE:    state_d = (CS_HIGH > 1) ? GUARD : IDLE;
            GUARD:   if (guard_q == 8'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            guard_q <= '0;
            we_q    <= 1'b0;
            abort_q <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= set_ack;
            if (start) begin
                we_q    <= wb.wb_we_i;
                abort_q <= 1'b0;
            end else if (state_q == SHIFT && !wb.wb_cyc_i) begin
                abort_q <= 1'b1;
            end
            if (set_ack && state_q == SHIFT && !we_q) dat_q <= rx_byte;
            // DONE is the first of the CS_HIGH high cycles, GUARD covers the rest.
            if (state_q == DONE)
                guard_q <= 8'((CS_HIGH > 1) ? CS_HIGH - 2 : 0);
            else if (state_q == GUARD && guard_q != 8'd0)
                guard_q <= guard_q - 8'd1;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = 1'b0;
    assign wb.wb_rty_o = 1'b0;
    assign wb.wb_dat_o = dat_q;
endmodule

// File: tb/tb_wb_spi_sram.sv
// Bench for wb_spi_sram: SPI SRAM model on the pins, per-cycle check of bus and SPI pins against
// a transaction-level schedule (accept edge, frame bits, ack edge, read data), directed then random.
module tb_wb_spi_sram;
    localparam int CS_HIGH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic miso = 1'b0;
    logic sck, cs_n, mosi;

    wb_spi_sram_if bus ();

    wb_spi_sram #(.CLK_DIV(1), .CS_HIGH(CS_HIGH)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wb         (bus),
        .spi_sck_o  (sck),
        .spi_cs_n_o (cs_n),
        .spi_mosi_o (mosi),
        .spi_miso_i (miso)
    );

    always #5 clk = ~clk;

    int n_edge = 0;
    always @(posedge clk) n_edge <= n_edge + 1;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at edge %0d: got %0h, expected %0h", name, n_edge, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        errors++;
        $display("FAIL %s at edge %0d: expected event did not occur", name, n_edge);
    endtask

    // ---------------- reference memory and transaction schedule ----------------
    logic [7:0] ref_mem  [int];
    logic [7:0] sram_mem [int];

    function automatic logic [7:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] sram_rd(input int a);
        return sram_mem.exists(a) ? sram_mem[a] : 8'h00;
    endfunction

    int          t0        = -1;   // edge that accepts the current request
    bit          t_null    = 1'b0;
    logic [39:0] exp_frame = '0;
    int          ack_at    = -1;
    int          dat_at    = -1;
    logic [7:0]  rd_val    = '0;
    logic [7:0]  exp_dat   = '0;
    int          free_edge = 0;    // first edge at which the slave can accept again
    bit          in_reset  = 1'b1;

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        int k;
        bit win;
        #1;
        win = (t0 >= 0) && !t_null && (n_edge >= t0) && (n_edge <= t0 + 79);
        if (n_edge == dat_at) exp_dat = rd_val;
        check("ack", bus.wb_ack_o, n_edge == ack_at);
        check("dat_o", bus.wb_dat_o, exp_dat);
        check("err_rty", {bus.wb_err_o, bus.wb_rty_o}, 2'b00);
        if (win) begin
            k = n_edge - t0;
            check("cs_n_frame", cs_n, 1'b0);
            check("sck_frame", sck, k % 2);
            check("mosi_bit", mosi, exp_frame[39 - k / 2]);
        end else begin
            check("cs_n_idle", cs_n, 1'b1);
            check("sck_idle", sck, 1'b0);
            if (in_reset) check("mosi_reset", mosi, 1'b0);
        end
    end

    // ---------------- SPI SRAM model ----------------
    logic [39:0] cap_q[$];
    bit          p_sck = 1'b0;
    bit          p_cs  = 1'b1;
    int          nb    = 0;
    logic [7:0]  s_cmd, s_dat, v;
    logic [23:0] s_adr;
    logic [39:0] s_frame;

    always @(posedge clk) begin
        #1;
        if (!cs_n && p_cs) nb = 0;
        if (!cs_n && sck && !p_sck) begin
            nb++;
            s_frame = {s_frame[38:0], mosi};
            if (nb <= 8)       s_cmd = {s_cmd[6:0], mosi};
            else if (nb <= 32) s_adr = {s_adr[22:0], mosi};
            else               s_dat = {s_dat[6:0], mosi};
            if (nb >= 33 && s_cmd == 8'h03) begin
                v    = sram_rd(int'(s_adr[22:0]));
                miso = v[40 - nb];
            end
        end
        if (cs_n && !p_cs) begin
            if (nb == 40) begin
                cap_q.push_back(s_frame);
                if (s_cmd == 8'h02) sram_mem[int'(s_adr[22:0])] = s_dat;
            end
            miso = 1'b0;
            nb   = 0;
        end
        p_sck = sck;
        p_cs  = cs_n;
    end

    // ---------------- bus driver ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_bus();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
    endtask

    task automatic start_req(input bit we, input logic [22:0] a, input logic [7:0] d,
                             input bit sel, output int t_acc);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = a;
        bus.wb_dat_i = d;
        bus.wb_sel_i = sel;
        t_acc  = (n_edge + 1 > free_edge) ? n_edge + 1 : free_edge;
        t0     = t_acc;
        t_null = we && !sel;
        exp_frame = {(we ? 8'h02 : 8'h03), 1'b0, a, (we ? d : 8'h00)};
        dat_at = -1;
        if (t_null) begin
            ack_at    = t_acc;
            free_edge = t_acc + 2;
        end else begin
            ack_at    = t_acc + 80;
            free_edge = t_acc + 81 + CS_HIGH;
            if (we) ref_mem[int'(a)] = d;
            else begin
                rd_val = ref_rd(int'(a));
                dat_at = ack_at;
            end
        end
    endtask

    task automatic wait_ack(input string name);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.wb_ack_o === 1'b1) return;
        end
        fail_now(name);
    endtask

    task automatic xfer(input bit we, input logic [22:0] a, input logic [7:0] d,
                        input bit sel, input bit hold, output int t_acc);
        start_req(we, a, d, sel, t_acc);
        wait_ack("ack_timeout");
        if (!hold) idle_bus();
    endtask

    task automatic pop_cap(input string name, input logic [39:0] exp);
        if (cap_q.size() == 0) fail_now(name);
        else check(name, cap_q.pop_front(), exp);
    endtask

    task automatic preload(input int a, input logic [7:0] d);
        ref_mem[a]  = d;
        sram_mem[a] = d;
    endtask

    int ta, tb_, a1, a2;
    bit rwe, rsel;
    logic [22:0] radr;
    logic [7:0]  rdat;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = '0;   bus.wb_dat_i = '0;   bus.wb_sel_i = '0;
        preload(23'h7FFFFF, 8'h3C);
        preload(23'h000100, 8'h11);
        preload(23'h000101, 8'h22);
        repeat (4) tick();
        check("reset_cs_n", cs_n, 1'b1);
        check("reset_ack", bus.wb_ack_o, 1'b0);
        rst = 1'b0;
        in_reset  = 1'b0;
        free_edge = n_edge + 1;

        // Write 0xA5 to 0x012345.
        xfer(1'b1, 23'h012345, 8'hA5, 1'b1, 1'b0, ta);
        check("wr_ack_latency", n_edge - ta, 80);
        pop_cap("wr_frame", 40'h02012345A5);

        // Read 0x7FFFFF, data held after the ack.
        xfer(1'b0, 23'h7FFFFF, 8'h00, 1'b1, 1'b0, ta);
        pop_cap("rd_frame", 40'h037FFFFF00);
        check("rd_data", bus.wb_dat_o, 8'h3C);
        repeat (5) tick();
        check("rd_data_hold", bus.wb_dat_o, 8'h3C);

        // Null write: immediate ack, no frame.
        xfer(1'b1, 23'h000010, 8'h77, 1'b0, 1'b0, ta);
        check("null_latency", n_edge - ta, 0);
        repeat (3) tick();
        check("null_no_frame", cap_q.size(), 0);

        // Back-to-back reads with stb held.
        xfer(1'b0, 23'h000100, 8'h00, 1'b1, 1'b1, ta);
        a1 = n_edge;
        check("b2b_data0", bus.wb_dat_o, 8'h11);
        xfer(1'b0, 23'h000101, 8'h00, 1'b1, 1'b0, ta);
        a2 = n_edge;
        check("b2b_spacing", a2 - a1, 83);
        check("b2b_data1", bus.wb_dat_o, 8'h22);
        pop_cap("b2b_frame0", 40'h0300010000);
        pop_cap("b2b_frame1", 40'h0300010100);

        // Cycle abandoned during frame bit 10: frame completes, no ack, data kept.
        start_req(1'b0, 23'h000100, 8'h00, 1'b1, ta);
        while (n_edge < ta + 20) tick();
        idle_bus();
        ack_at = -1;
        dat_at = -1;
        while (n_edge < ta + 84) tick();
        pop_cap("abort_frame", 40'h0300010000);
        check("abort_dat_kept", bus.wb_dat_o, 8'h22);

        // Reset during frame bit 20.
        start_req(1'b0, 23'h7FFFFF, 8'h00, 1'b1, ta);
        while (n_edge < ta + 40) tick();
        rst = 1'b1;
        in_reset = 1'b1;
        idle_bus();
        t0 = -1; ack_at = -1; dat_at = -1; exp_dat = 8'h00;
        tick();
        check("rst_mid_cs_n", cs_n, 1'b1);
        check("rst_mid_sck", sck, 1'b0);
        check("rst_mid_ack", bus.wb_ack_o, 1'b0);
        rst = 1'b0;
        in_reset  = 1'b0;
        free_edge = n_edge + 1;
        tick();
        check("rst_partial_dropped", cap_q.size(), 0);
        xfer(1'b1, 23'h000001, 8'h5A, 1'b1, 1'b0, ta);
        pop_cap("post_rst_wr_frame", 40'h020000015A);
        xfer(1'b0, 23'h000001, 8'h00, 1'b1, 1'b0, ta);
        check("post_rst_readback", bus.wb_dat_o, 8'h5A);
        pop_cap("post_rst_rd_frame", 40'h0300000100);

        // Random mix over a small address window.
        for (int i = 0; i < 40; i++) begin
            rwe  = $urandom_range(0, 1);
            rsel = ($urandom_range(0, 4) != 0);
            radr = 23'($urandom_range(0, 7));
            rdat = 8'($urandom);
            xfer(rwe, radr, rdat, rsel, ($urandom_range(0, 2) == 0), tb_);
            if (!(rwe && !rsel)) pop_cap("rand_frame", exp_frame);
            if (!rwe) check("rand_rd_data", bus.wb_dat_o, rd_val);
            if (!bus.wb_stb_i) repeat ($urandom_range(0, 3)) tick();
        end
        idle_bus();
        repeat (100) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/wb_spi_sram.md
Name: wb_spi_sram

Overview:
Wishbone slave that answers single-beat 8-bit Wishbone cycles by running one SPI SRAM transaction per access (23LC-style 0x03 READ / 0x02 WRITE, 24-bit address).
It sits on a slave port of the 2x2 Wishbone interconnect and receives the 23-bit slave address, with the interconnect's select bit already stripped.
It is the responder end of the bus, and it is the only path from the design to external memory.

Parameters:
ADDR_WIDTH, 23, Wishbone slave address width; zero-extended to 24 SPI address bits.
DATA_WIDTH, 8, Wishbone data width; only 8 is supported.
SEL_WIDTH, DATA_WIDTH/8, Wishbone select width.
CLK_DIV, 1, clk_i cycles per SCK half-period; must be 1 or more.
CS_HIGH, 2, minimum clk_i cycles CS_N stays high between transactions; must be 1 or more.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_adr_i  in  ADDR_WIDTH  byte address
wb_we_i  in  1  write enable
wb_sel_i  in  SEL_WIDTH  byte select
wb_dat_i  in  DATA_WIDTH  write data
wb_ack_o  out  1  acknowledge, one-cycle pulse
wb_err_o  out  1  error, tied 0
wb_rty_o  out  1  retry, tied 0
wb_dat_o  out  DATA_WIDTH  read data
spi_sck_o  out  1  SPI clock, mode 0
spi_cs_n_o  out  1  chip select, active low
spi_mosi_o  out  1  SPI data to SRAM
spi_miso_i  in  1  SPI data from SRAM

Behaviour:
- Reset values: wb_ack_o=0, wb_dat_o=0, spi_cs_n_o=1, spi_sck_o=0, spi_mosi_o=0. FSM goes to IDLE; guard counter is cleared.
- FSM states: IDLE, SHIFT, DONE, GUARD.
- IDLE, accept condition: cyc&stb&!ack sampled at edge T0. On accept, latch adr, we, dat and sel.
- IDLE, null write: we=1 with sel=0 pulses ack at T0+1. No SPI activity. Stay in IDLE.
- IDLE, normal access: go to SHIFT.
- Frame format: 40 bits, MSB first, as {cmd[7:0], 1'b0, adr[22:0], data[7:0]}.
  - cmd = 0x03 for read, 0x02 for write.
  - For reads, MOSI drives 0 during the data byte.
- SHIFT, start: at T0+1, cs_n=0, sck=0, mosi=bit39.
- SHIFT, SCK timing: SCK toggles every CLK_DIV cycles. Each bit occupies 2*CLK_DIV cycles, low phase first.
- SHIFT, MOSI update: MOSI changes only on the edge where SCK falls.
- SHIFT, MISO sampling: MISO is sampled on the edge where SCK falls, i.e. the end of the high phase. Bits 7..0 of the read byte are taken in frame bits 32..39.
- SHIFT end: after bit 0's high phase, go to DONE with cs_n=1 and sck=0.
- DONE, cycle timing: DONE occupies cycle T0+1+80*CLK_DIV, which is 81 cycles for CLK_DIV=1.
- DONE, ack and data: ack=1 for exactly one cycle. For reads, wb_dat_o is updated in the same cycle. wb_dat_o holds until the next completed read.
- GUARD: hold cs_n=1 for CS_HIGH cycles counted from DONE, then go to IDLE. A request pending during GUARD waits; it is not lost.
- Abort: if cyc falls during SHIFT, the SPI frame still completes so the SRAM is not left mid-command. In that case ack is suppressed and wb_dat_o is not updated.
- Bus inputs ignored: adr, dat, we and sel changes after accept have no effect.
- Reset mid-operation: on the next edge cs_n=1 and sck=0, no ack is issued, and the FSM is in IDLE.
- Back-to-back: at most one transaction is outstanding. The minimum spacing between consecutive acks is 81+CS_HIGH cycles (CLK_DIV=1).

Decomposition:
- Shared package wb_spi_sram_pkg holds:
  - CMD_READ=8'h03 and CMD_WRITE=8'h02;
  - FRAME_BITS=40 and DATA_BITS=8;
  - the state enum {IDLE, SHIFT, DONE, GUARD}.
- One sub-module, spi_shift_engine, implements:
  - the 40-bit shift register, CLK_DIV prescaler and bit counter;
  - SCK/MOSI generation and MISO capture;
  - a start/busy/done handshake.
  The top level owns the Wishbone handshake, the FSM and the guard counter.

Test Plan:
1. Write adr=0x012345, dat=0xA5, sel=1, CLK_DIV=1 -> MOSI stream 0x02,0x01,0x23,0x45,0xA5; cs_n low for 80 cycles; ack one cycle at T0+81.
2. Read adr=0x7FFFFF, SRAM model returns 0x3C -> MOSI 0x03,0x7F,0xFF,0xFF,0x00; wb_dat_o=0x3C in the ack cycle, held afterwards.
3. Write with sel=0 -> ack at T0+1; cs_n stays 1 and sck stays 0 throughout.
4. Two reads back-to-back with stb held, CS_HIGH=2 -> cs_n high for at least 2 cycles between frames; both acks present; data 0x11 then 0x22.
5. Read, then cyc dropped at frame bit 10 -> full 40-bit frame still clocks; no ack; wb_dat_o keeps its previous value.
6. rst_i asserted at frame bit 20 -> next edge cs_n=1, sck=0, ack=0; a subsequent write adr=0x000001 dat=0x5A completes normally.
